// File: rtl/vga_scanout_if.sv
// Scan-out port bundle: frame-buffer read port, renderer swap handshake
// and VGA output pins.
interface vga_scanout_if;
  logic [18:0] pix_addr;
  logic [8:0]  pix_data;
  logic        render_done;
  logic        swap;
  logic        swap_pending;
  logic        frame_start;
  logic [2:0]  vga_r;
  logic [2:0]  vga_g;
  logic [2:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_de;

  modport master (
    output pix_addr,
    input  pix_data,
    input  render_done,
    output swap,
    output swap_pending,
    output frame_start,
    output vga_r,
    output vga_g,
    output vga_b,
    output vga_hs,
    output vga_vs,
    output vga_de
  );

  modport slave (
    input  pix_addr,
    output pix_data,
    output render_done,
    input  swap,
    input  swap_pending,
    input  frame_start,
    input  vga_r,
    input  vga_g,
    input  vga_b,
    input  vga_hs,
    input  vga_vs,
    input  vga_de
  );
endinterface

// File: rtl/vga_scanout.sv
// VGA raster timing, frame-buffer scan-out and vblank-aligned
// buffer swap.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int RD_LAT   = 1
) (
  input logic clk,
  input logic rst,
  vga_scanout_if.master io
);

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST =
    10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST =
    10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [18:0] PIX_LAST = 19'(H_ACTIVE * V_ACTIVE - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PEND = 1'b1;

  logic [9:0]      h_q, h_d;
  logic [9:0]      v_q, v_d;
  logic [18:0]     addr_q, addr_d;
  logic [0:0]      state_q, state_d;
  logic            swap_q, swap_d;
  logic            fs_q, fs_d;
  logic [RD_LAT:0] de_q, de_d;
  logic [RD_LAT:0] hs_q, hs_d;
  logic [RD_LAT:0] vs_q, vs_d;
  logic [8:0]      rgb_q, rgb_d;

  logic h_end, v_end, active, hs_on, vs_on, vb_entry;

  always_comb begin
    h_end    = (h_q == H_LAST);
    v_end    = (v_q == V_LAST);
    active   = (h_q < H_ACT) && (v_q < V_ACT);
    hs_on    = (h_q >= HS_BEG) && (h_q < HS_END);
    vs_on    = (v_q >= VS_BEG) && (v_q < VS_END);
    vb_entry = (h_q == 10'd0) && (v_q == V_ACT);

    h_d = h_end ? 10'd0 : h_q + 10'd1;
    v_d = v_q;
    if (h_end) v_d = v_end ? 10'd0 : v_q + 10'd1;

    // Wrapping after the last pixel keeps the blank-time address in range.
    addr_d = addr_q;
    if (active)
      addr_d = (addr_q == PIX_LAST) ? 19'd0 : addr_q + 19'd1;
    if (h_end && v_end) addr_d = 19'd0;

    fs_d = (h_q == 10'd0) && (v_q == 10'd0);

    de_d = {de_q[RD_LAT-1:0], active};
    hs_d = {hs_q[RD_LAT-1:0], hs_on ? SYNC_POL : ~SYNC_POL};
    vs_d = {vs_q[RD_LAT-1:0], vs_on ? SYNC_POL : ~SYNC_POL};
    rgb_d = de_q[RD_LAT-1] ? io.pix_data : 9'd0;

    state_d = state_q;
    swap_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (io.render_done) state_d = S_PEND;
      end
      S_PEND: begin
        if (vb_entry) begin
          swap_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q     <= 10'd0;
      v_q     <= 10'd0;
      addr_q  <= 19'd0;
      state_q <= S_IDLE;
      swap_q  <= 1'b0;
      fs_q    <= 1'b0;
      de_q    <= '0;
      hs_q    <= {(RD_LAT+1){~SYNC_POL}};
      vs_q    <= {(RD_LAT+1){~SYNC_POL}};
      rgb_q   <= 9'd0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      addr_q  <= addr_d;
      state_q <= state_d;
      swap_q  <= swap_d;
      fs_q    <= fs_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      rgb_q   <= rgb_d;
    end
  end

  assign io.pix_addr     = addr_q;
  assign io.swap         = swap_q;
  assign io.swap_pending = (state_q == S_PEND);
  assign io.frame_start  = fs_q;
  assign io.vga_r        = rgb_q[8:6];
  assign io.vga_g        = rgb_q[5:3];
  assign io.vga_b        = rgb_q[2:0];
  assign io.vga_de       = de_q[RD_LAT];
  assign io.vga_hs       = hs_q[RD_LAT];
  assign io.vga_vs       = vs_q[RD_LAT];

endmodule
